// File: rtl/latch_pkg.sv
// Shared constants for the latch event logger: record layout, defaults, counter saturation.
package latch_pkg;

  localparam int unsigned DEFAULT_DEPTH   = 4;
  localparam int unsigned DEFAULT_STAMP_W = 8;

  // Flag bit offsets above the stamp field; a record is {src, rise, stamp}
  localparam int unsigned SRC_BIT  = 1;
  localparam int unsigned RISE_BIT = 0;

  localparam logic SRC_C = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam int unsigned        CNT_W   = 8;
  localparam logic [CNT_W-1:0]   CNT_SAT = {CNT_W{1'b1}};

  // Saturating increment for the rising-edge counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus a third flop for edge detection of one async input.
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic edge_c,
  output logic level
);

  logic s1, s2, s3;

  // Synchronizer chain; all stages clear to 0 so a high input after reset reads as a rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level  = s2;
  assign edge_c = s2 ^ s3;

endmodule

// File: rtl/latch_event_logger.sv
// Timestamps edges on the latch outputs c/d into a small FIFO and counts rising edges.
module latch_event_logger
  import latch_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned STAMP_W = DEFAULT_STAMP_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 c_in,
  input  logic                 d_in,
  input  logic                 clr,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [STAMP_W+1:0]   out_data,
  output logic [CNT_W-1:0]     count_c,
  output logic [CNT_W-1:0]     count_d,
  output logic                 overflow
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned REC_W = STAMP_W + 2;

  logic c_edge, c_level, d_edge, d_level;

  edge_sync u_sync_c (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (c_in),
    .edge_c   (c_edge),
    .level    (c_level)
  );

  edge_sync u_sync_d (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (d_in),
    .edge_c   (d_edge),
    .level    (d_level)
  );

  logic [STAMP_W-1:0] stamp;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      fill;

  logic               rd;
  logic [CW-1:0]      free;
  logic [1:0]         pend;
  logic               we0, we1, drop;
  logic [REC_W-1:0]   rec_c, rec_d, rec0, rec1, head_nxt;
  logic [AW-1:0]      wr_ptr1, rd_ptr_nxt;
  logic [CW-1:0]      n_wr, fill_nxt;

  // Free-running timestamp; only reset clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stamp <= '0;
    else          stamp <= stamp + STAMP_W'(1);
  end

  // Admission of up to two events (c first) against space freed by a same-cycle read
  always_comb begin
    rec_c = '0;
    rec_c[STAMP_W-1:0]        = stamp;
    rec_c[STAMP_W + RISE_BIT] = c_level;
    rec_c[STAMP_W + SRC_BIT]  = SRC_C;
    rec_d = '0;
    rec_d[STAMP_W-1:0]        = stamp;
    rec_d[STAMP_W + RISE_BIT] = d_level;
    rec_d[STAMP_W + SRC_BIT]  = SRC_D;

    rd   = out_valid && out_ready;
    free = CW'(DEPTH) - fill + CW'(rd);
    pend = {1'b0, c_edge} + {1'b0, d_edge};

    we0  = (pend != 2'd0) && (free != '0);
    we1  = (pend == 2'd2) && (free >= CW'(2));
    drop = ((pend == 2'd2) && (free < CW'(2))) || ((pend == 2'd1) && (free == '0));

    rec0 = c_edge ? rec_c : rec_d;
    rec1 = rec_d;

    wr_ptr1    = wr_ptr + AW'(1);
    rd_ptr_nxt = rd ? rd_ptr + AW'(1) : rd_ptr;
    n_wr       = CW'(we0) + CW'(we1);
    fill_nxt   = fill + n_wr - CW'(rd);

    // Next head: a slot being written this cycle only becomes head if the FIFO drains to it
    if (we0 && (rd_ptr_nxt == wr_ptr))       head_nxt = rec0;
    else if (we1 && (rd_ptr_nxt == wr_ptr1)) head_nxt = rec1;
    else                                     head_nxt = mem[rd_ptr_nxt];
  end

  // Record storage; no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (we0) mem[wr_ptr]  <= rec0;
      if (we1) mem[wr_ptr1] <= rec1;
    end
  end

  // FIFO pointers, registered head/valid and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr + AW'(n_wr);
      fill      <= fill_nxt;
      out_valid <= (fill_nxt != '0);
      out_data  <= head_nxt;
      overflow  <= overflow | drop;
    end
  end

  // Rising-edge counters, counting dropped events too
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_c <= '0;
      count_d <= '0;
    end else if (clr) begin
      count_c <= '0;
      count_d <= '0;
    end else begin
      if (c_edge && c_level) count_c <= sat_inc(count_c);
      if (d_edge && d_level) count_d <= sat_inc(count_d);
    end
  end

endmodule
